// File: rtl/sisc_fetch_queue_if.sv
// rtl/sisc_fetch_queue_if.sv - fetch front-end bus: imem port, decode head, redirect, occupancy
interface sisc_fetch_queue_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               ir_valid;
  logic [INSTR_W-1:0] ir_instr;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_ready;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic [CNT_W-1:0]   q_count;

  modport master (
    output imem_req, imem_addr, ir_valid, ir_instr, ir_pc, q_count,
    input  imem_rvalid, imem_rdata, ir_ready, br_taken, br_target
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, ir_instr, ir_pc, q_count,
    output imem_rvalid, imem_rdata, ir_ready, br_taken, br_target
  );
endinterface

// File: rtl/sisc_fetch_queue.sv
// rtl/sisc_fetch_queue.sv - instruction fetch PC, single-outstanding imem port and prefetch queue
module sisc_fetch_queue #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0,
  parameter int PC_INC   = 1
) (
  input logic                  clk,
  input logic                  rst_f,
  sisc_fetch_queue_if.master   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] INC     = ADDR_W'(PC_INC);

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               outst_q, outst_d;
  logic               discard_q, discard_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  logic issue, rsp, push, pop;

  // Issue only with nothing in flight; the single reserved slot keeps pushes from overflowing.
  assign issue = rst_f & ~outst_q & ~bus.br_taken & (count_q < DEPTH_C);
  assign rsp   = bus.imem_rvalid & outst_q;
  assign push  = rsp & ~discard_q & ~bus.br_taken;
  assign pop   = (count_q != '0) & bus.ir_ready & ~bus.br_taken;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.ir_valid  = (count_q != '0);
  assign bus.ir_instr  = instr_mem_q[rd_ptr_q];
  assign bus.ir_pc     = pc_mem_q[rd_ptr_q];
  assign bus.q_count   = count_q;

  // Next-state: response retire, issue, then redirect overrides queue and PC.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (rsp) begin
      outst_d   = 1'b0;
      discard_d = 1'b0;
    end
    if (issue) begin
      outst_d    = 1'b1;
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + INC;
    end

    if (bus.br_taken) begin
      fetch_pc_d = bus.br_target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      // A response still in flight belongs to the old path and must be dropped on arrival.
      if (outst_q && !bus.imem_rvalid) discard_d = 1'b1;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      fetch_pc_q <= RST_PC;
      req_pc_q   <= '0;
      outst_q    <= 1'b0;
      discard_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_sisc_fetch_queue.sv
// tb/tb_sisc_fetch_queue.sv - self-checking bench for sisc_fetch_queue
module tb_sisc_fetch_queue;
  logic clk = 1'b0;
  logic rst_f = 1'b0;
  always #5 clk = ~clk;

  sisc_fetch_queue_if #(.ADDR_W(16), .INSTR_W(32), .DEPTH(4)) bus ();

  sisc_fetch_queue #(.ADDR_W(16), .INSTR_W(32), .DEPTH(4), .RESET_PC(0), .PC_INC(1)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus.master)
  );

  typedef struct { logic [15:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { int due; logic [31:0] data; } pend_t;
  typedef struct {
    bit rdy; bit br; logic [15:0] tgt;
    bit e_req; logic [15:0] e_addr; bit e_valid; logic [15:0] e_pc; logic [2:0] e_cnt;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat_fixed = 1;
  bit spur_en = 0;

  ent_t  mq[$];
  pend_t pend[$];
  logic [15:0] m_pc = 16'h0, m_reqpc = 16'h0;
  bit m_out = 0, m_disc = 0;

  logic        s_req, s_valid;
  logic [15:0] s_addr, s_pc;
  logic [31:0] s_instr;
  logic [2:0]  s_cnt;

  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.ir_ready    = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_target   = '0;
  end

  function automatic logic [31:0] memf(input logic [15:0] a);
    return 32'hA000_0000 + {16'h0, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit rdy, input bit br, input logic [15:0] tgt, input bit inj);
    logic        rv;
    logic [31:0] rd;
    bit          exp_req;
    int          l;
    @(negedge clk);
    rv = 1'b0;
    rd = $urandom;
    if (inj) rv = 1'b1;
    else if (pend.size() > 0 && pend[0].due == cyc) begin
      rv = 1'b1;
      rd = pend[0].data;
      void'(pend.pop_front());
    end else if (pend.size() == 0 && spur_en && $urandom_range(7) == 0) rv = 1'b1;
    bus.ir_ready    = rdy;
    bus.br_taken    = br;
    bus.br_target   = tgt;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    #1;
    s_req = bus.imem_req; s_addr = bus.imem_addr; s_valid = bus.ir_valid;
    s_pc = bus.ir_pc; s_instr = bus.ir_instr; s_cnt = bus.q_count;

    exp_req = !m_out && !br && (mq.size() < 4);
    chk("imem_req", 32'(s_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", 32'(s_addr), 32'(m_pc));
    chk("ir_valid", 32'(s_valid), 32'(mq.size() != 0));
    chk("q_count", 32'(s_cnt), 32'(mq.size()));
    if (mq.size() != 0) begin
      chk("ir_pc", 32'(s_pc), 32'(mq[0].pc));
      chk("ir_instr", s_instr, mq[0].instr);
    end

    if (s_req) begin
      l = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
      pend.push_back('{cyc + l, memf(s_addr)});
    end

    if (br) begin
      if (m_out && rv) begin m_out = 0; m_disc = 0; end
      else if (m_out) m_disc = 1;
      mq.delete();
      m_pc = tgt;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (m_out && rv) begin
        m_out = 0;
        if (m_disc) m_disc = 0;
        else mq.push_back('{m_reqpc, rd});
      end
      if (exp_req) begin m_out = 1; m_reqpc = m_pc; m_pc = m_pc + 16'd1; end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_f = 1'b0;
    bus.br_taken = 1'b0; bus.imem_rvalid = 1'b0; bus.ir_ready = 1'b0;
    #1;
    chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
    chk("rst_ir_valid", 32'(bus.ir_valid), 32'h0);
    chk("rst_q_count", 32'(bus.q_count), 32'h0);
    chk("rst_ir_instr", bus.ir_instr, 32'h0);
    chk("rst_ir_pc", 32'(bus.ir_pc), 32'h0);
    mq.delete(); pend.delete();
    m_pc = 16'h0; m_out = 0; m_disc = 0;
    @(posedge clk);
    #1 rst_f = 1'b1;
  endtask

  task automatic wait_req(input int lim, output bit ok, output int n);
    ok = 0; n = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      n = i + 1;
      if (s_req) ok = 1;
    end
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      if (s_valid) ok = 1;
    end
  endtask

  function automatic vec_t mkv(bit rdy, bit br, logic [15:0] tgt, bit rq, logic [15:0] ad,
                               bit v, logic [15:0] pc, logic [2:0] cnt);
    vec_t r;
    r.rdy = rdy; r.br = br; r.tgt = tgt; r.e_req = rq; r.e_addr = ad;
    r.e_valid = v; r.e_pc = pc; r.e_cnt = cnt;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[18];
    bit ok;
    int n;
    logic [15:0] tg;

    // Fill with ir_ready=0 at L=1, then drain and refill, then redirect on a response cycle.
    tbl[0]  = mkv(0, 0, 16'h0,  1, 16'h0, 0, 16'h0, 3'd0);
    tbl[1]  = mkv(0, 0, 16'h0,  0, 16'h0, 0, 16'h0, 3'd0);
    tbl[2]  = mkv(0, 0, 16'h0,  1, 16'h1, 1, 16'h0, 3'd1);
    tbl[3]  = mkv(0, 0, 16'h0,  0, 16'h0, 1, 16'h0, 3'd1);
    tbl[4]  = mkv(0, 0, 16'h0,  1, 16'h2, 1, 16'h0, 3'd2);
    tbl[5]  = mkv(0, 0, 16'h0,  0, 16'h0, 1, 16'h0, 3'd2);
    tbl[6]  = mkv(0, 0, 16'h0,  1, 16'h3, 1, 16'h0, 3'd3);
    tbl[7]  = mkv(0, 0, 16'h0,  0, 16'h0, 1, 16'h0, 3'd3);
    tbl[8]  = mkv(0, 0, 16'h0,  0, 16'h0, 1, 16'h0, 3'd4);
    tbl[9]  = mkv(0, 0, 16'h0,  0, 16'h0, 1, 16'h0, 3'd4);
    tbl[10] = mkv(1, 0, 16'h0,  0, 16'h0, 1, 16'h0, 3'd4);
    tbl[11] = mkv(1, 0, 16'h0,  1, 16'h4, 1, 16'h1, 3'd3);
    tbl[12] = mkv(1, 0, 16'h0,  0, 16'h0, 1, 16'h2, 3'd2);
    tbl[13] = mkv(1, 0, 16'h0,  1, 16'h5, 1, 16'h3, 3'd2);
    tbl[14] = mkv(1, 0, 16'h0,  0, 16'h0, 1, 16'h4, 3'd1);
    tbl[15] = mkv(1, 0, 16'h0,  1, 16'h6, 1, 16'h5, 3'd1);
    tbl[16] = mkv(1, 1, 16'h20, 0, 16'h0, 0, 16'h0, 3'd0);
    tbl[17] = mkv(1, 0, 16'h0,  1, 16'h20, 0, 16'h0, 3'd0);

    lat_fixed = 1; spur_en = 0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rdy, tbl[i].br, tbl[i].tgt, 1'b0);
      chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), 32'(s_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_cnt", i), 32'(s_cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_pc", i), 32'(s_pc), 32'(tbl[i].e_pc));
        chk($sformatf("tbl%0d_instr", i), s_instr, memf(tbl[i].e_pc));
      end
    end

    // Redirect while the request to 5 is in flight with L=3.
    do_reset();
    lat_fixed = 3;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      if (s_req && s_addr == 16'h5) ok = 1;
    end
    chk("br_find_req5", 32'(ok), 32'h1);
    step(1'b1, 1'b1, 16'h0040, 1'b0);
    chk("br_no_issue", 32'(s_req), 32'h0);
    wait_req(20, ok, n);
    chk("br_req_seen", 32'(ok), 32'h1);
    chk("br_req_addr", 32'(s_addr), 32'h40);
    chk("br_req_delay", 32'(n), 32'd3);
    wait_valid(20, ok);
    chk("br_valid_seen", 32'(ok), 32'h1);
    chk("br_first_pc", 32'(s_pc), 32'h40);

    // Redirect coinciding with a response and a pop.
    do_reset();
    lat_fixed = 1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0080, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("coin_count", 32'(s_cnt), 32'h0);
    chk("coin_req", 32'(s_req), 32'h1);
    chk("coin_addr", 32'(s_addr), 32'h80);

    // Reset mid-request, then a stale response right after release.
    lat_fixed = 3;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("stale_req", 32'(s_req), 32'h1);
    chk("stale_addr", 32'(s_addr), 32'h0);
    wait_valid(20, ok);
    chk("stale_valid", 32'(ok), 32'h1);
    chk("stale_pc", 32'(s_pc), 32'h0);
    chk("stale_instr", s_instr, memf(16'h0));

    // Fetch PC wrap.
    lat_fixed = 1;
    step(1'b1, 1'b1, 16'hFFFF, 1'b0);
    wait_req(20, ok, n);
    chk("wrap_req1", 32'(s_addr), 32'hFFFF);
    wait_req(20, ok, n);
    chk("wrap_req2", 32'(s_addr), 32'h0000);

    // Randomised traffic against the model.
    do_reset();
    lat_fixed = 0; spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) do_reset();
      tg = ($urandom_range(3) == 0) ? 16'hFFFC + 16'($urandom_range(3)) : 16'($urandom);
      step($urandom_range(3) != 0, $urandom_range(15) == 0, tg, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
